windowed_reg_file: RTL and testbench

- Register file with a sliding window, used in the p18240 datapath.
- Holds 32 physical 16-bit registers; the processor sees an 8-register window selected by a 5-bit window index.
- Provides two combinational read ports (A, B), one write port addressed through selA, a 128-bit debug view port, and a window-limit flag.
- Built from a write-enable demux, two 32:1 read muxes, and enable-loaded registers: 32 data registers plus one index register.

---
 rtl/windowed_reg_file_if.sv | 39 +++
 rtl/windowed_reg_file.sv | 110 +++++++++++
 tb/tb_windowed_reg_file.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/windowed_reg_file_if.sv
// windowed_reg_file_if
//   Bundles the data/control signals of the windowed register file.
//   master : driver side (datapath or testbench), drives in/sel/load/window.
//   slave  : register file side, returns read data, view and limit flag.
//   Signals:
//     in        write data
//     selA      logical read A register, also the write address
//     selB      logical read B register
//     load_L    active-low write enable
//     winAddSub 2'b10 advance window, 2'b01 retreat, otherwise hold
//     outA/outB combinational read data
//     outView   8-slot preview of the window after the next edge
//     w         window index sits at the advance limit
interface windowed_reg_file_if #(
    parameter int WIDTH  = 16,
    parameter int WIN_SZ = 8
);
    localparam int SEL_W = $clog2(WIN_SZ);

    logic [WIDTH-1:0]        in;
    logic [SEL_W-1:0]        selA;
    logic [SEL_W-1:0]        selB;
    logic                    load_L;
    logic [1:0]              winAddSub;
    logic [WIDTH-1:0]        outA;
    logic [WIDTH-1:0]        outB;
    logic [WIN_SZ*WIDTH-1:0] outView;
    logic                    w;

    modport master (
        output in, selA, selB, load_L, winAddSub,
        input  outA, outB, outView, w
    );

    modport slave (
        input  in, selA, selB, load_L, winAddSub,
        output outA, outB, outView, w
    );
endinterface

// File: rtl/windowed_reg_file.sv
// windowed_reg_file
//   32 physical registers seen through an 8-register sliding window.
//   Logical register r maps to physical (r + index) mod NUM_REGS. The window
//   index moves by WIN_STEP; advancing stops once index reaches WIN_LIMIT,
//   retreating has no guard and wraps.
//   Ports:
//     clock  rising-edge clock
//     reset  synchronous active-high reset (clears registers and index)
//     bus    windowed_reg_file_if.slave (read/write/window/view signals)

// One enable-loaded storage register with synchronous clear.
module wrf_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clock) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

module windowed_reg_file #(
    parameter int WIDTH     = 16,
    parameter int NUM_REGS  = 32,
    parameter int WIN_STEP  = 4,
    parameter int WIN_LIMIT = 24
) (
    input  logic                 clock,
    input  logic                 reset,
    windowed_reg_file_if.slave   bus
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int WIN_SZ = 8;

    logic [NUM_REGS-1:0][WIDTH-1:0] phys;
    logic [NUM_REGS-1:0]            we;
    logic [IDX_W-1:0]               index;
    logic [IDX_W-1:0]               next_index;
    logic                           index_en;
    logic [IDX_W-1:0]               addr_a;
    logic [IDX_W-1:0]               addr_b;

    // Window offset add wraps naturally in IDX_W bits.
    assign addr_a = IDX_W'(bus.selA) + index;
    assign addr_b = IDX_W'(bus.selB) + index;

    assign bus.w = (index == IDX_W'(WIN_LIMIT));

    always_comb begin
        next_index = index;
        index_en   = 1'b0;
        case (bus.winAddSub)
            2'b10: begin
                index_en = 1'b1;
                if (!bus.w) next_index = index + IDX_W'(WIN_STEP);
            end
            2'b01: begin
                index_en   = 1'b1;
                next_index = index - IDX_W'(WIN_STEP);
            end
            default: ;
        endcase
    end

    wrf_reg #(.WIDTH(IDX_W)) u_index (
        .clock (clock),
        .reset (reset),
        .en    (index_en),
        .d     (next_index),
        .q     (index)
    );

    // Write demux: the address uses the pre-update index, so a write and a
    // window move in the same cycle land in the old window.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_phys
            assign we[gi] = !bus.load_L && (addr_a == IDX_W'(gi));

            wrf_reg #(.WIDTH(WIDTH)) u_reg (
                .clock (clock),
                .reset (reset),
                .en    (we[gi]),
                .d     (bus.in),
                .q     (phys[gi])
            );
        end
    endgenerate

    assign bus.outA = phys[addr_a];
    assign bus.outB = phys[addr_b];

    // View previews the window selected by next_index. Slots past the top of
    // the bank read zero (logical shift of the bank, not a rotate).
    always_comb begin
        logic [IDX_W:0] pos;
        bus.outView = '0;
        pos         = '0;
        for (int k = 0; k < WIN_SZ; k++) begin
            pos = {1'b0, next_index} + (IDX_W+1)'(k);
            if (pos < (IDX_W+1)'(NUM_REGS))
                bus.outView[k*WIDTH +: WIDTH] = phys[pos[IDX_W-1:0]];
        end
    end
endmodule

// File: tb/tb_windowed_reg_file.sv
module tb_windowed_reg_file;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clock = ~clock;

    windowed_reg_file_if #(.WIDTH(16), .WIN_SZ(8)) bus ();

    windowed_reg_file #(
        .WIDTH(16), .NUM_REGS(32), .WIN_STEP(4), .WIN_LIMIT(24)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock edge, then settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [127:0] view_exp;

    initial begin
        bus.in = 16'hFFFF; bus.selA = 3'd3; bus.selB = 3'd5;
        bus.load_L = 1'b1; bus.winAddSub = 2'b00;
        #2;

        // Reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_outA", 128'(bus.outA), 128'h0);
        chk("rst_outB", 128'(bus.outB), 128'h0);
        chk("rst_w", 128'(bus.w), 128'h0);
        chk("rst_view", bus.outView, 128'h0);

        // Basic write phys[2]=BEEF at index 0
        bus.load_L = 1'b0; bus.selA = 3'd2; bus.in = 16'hBEEF;
        tick();
        bus.load_L = 1'b1; bus.selB = 3'd2;
        #1;
        chk("wr_outB", 128'(bus.outB), 128'hBEEF);
        chk("wr_outA", 128'(bus.outA), 128'hBEEF);

        // load_L=1 must not write
        bus.in = 16'h1111;
        tick();
        chk("nowr_outA", 128'(bus.outA), 128'hBEEF);

        // Write phys[4]=1234, then advance
        bus.load_L = 1'b0; bus.selA = 3'd4; bus.in = 16'h1234;
        tick();
        bus.load_L = 1'b1; bus.winAddSub = 2'b10;
        #1;
        chk("adv_preview", 128'(bus.outView[15:0]), 128'h1234);
        tick();
        bus.winAddSub = 2'b00; bus.selA = 3'd0; bus.selB = 3'd6;
        #1;
        chk("adv_outA", 128'(bus.outA), 128'h1234);
        chk("adv_outB_phys10", 128'(bus.outB), 128'h0);
        chk("adv_view0", 128'(bus.outView[15:0]), 128'h1234);
        chk("adv_w", 128'(bus.w), 128'h0);

        // Five more advances: 4 -> 24
        bus.winAddSub = 2'b10;
        for (int i = 0; i < 5; i++) tick();
        bus.winAddSub = 2'b00;
        #1;
        chk("limit_w", 128'(bus.w), 128'h1);

        // Fill phys[24..31] = C000 + 16*k
        bus.load_L = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.selA = 3'(k); bus.in = 16'hC000 + 16'(k * 16);
            tick();
        end
        bus.load_L = 1'b1;
        view_exp = '0;
        for (int k = 0; k < 8; k++) view_exp[k*16 +: 16] = 16'hC000 + 16'(k * 16);
        #1;
        chk("limit_view", bus.outView, view_exp);

        // Blocked advance
        bus.winAddSub = 2'b10;
        #1;
        chk("blocked_preview", bus.outView, view_exp);
        tick();
        bus.winAddSub = 2'b00; bus.selA = 3'd0;
        #1;
        chk("blocked_w", 128'(bus.w), 128'h1);
        chk("blocked_outA", 128'(bus.outA), 128'hC000);

        // Retreat six times: 24 -> 0
        bus.winAddSub = 2'b01;
        for (int i = 0; i < 6; i++) tick();
        bus.winAddSub = 2'b00; bus.selA = 3'd2;
        #1;
        chk("idx0_outA", 128'(bus.outA), 128'hBEEF);

        // phys[1]=0101 at index 0
        bus.load_L = 1'b0; bus.selA = 3'd1; bus.in = 16'h0101;
        tick();
        bus.load_L = 1'b1;

        // Retreat wrap 0 -> 28; preview slots 4..7 are zero
        view_exp = '0;
        for (int k = 0; k < 4; k++) view_exp[k*16 +: 16] = 16'hC040 + 16'(k * 16);
        bus.winAddSub = 2'b01;
        #1;
        chk("wrap_preview", bus.outView, view_exp);
        tick();
        bus.winAddSub = 2'b00; bus.selA = 3'd5; bus.selB = 3'd6;
        #1;
        chk("wrap_w", 128'(bus.w), 128'h0);
        chk("wrap_outA_phys1", 128'(bus.outA), 128'h0101);
        chk("wrap_outB_phys2", 128'(bus.outB), 128'hBEEF);
        chk("wrap_view", bus.outView, view_exp);

        // Advance 28 -> 0 -> 4 -> 8
        bus.winAddSub = 2'b10;
        for (int i = 0; i < 3; i++) tick();
        bus.winAddSub = 2'b00; bus.selA = 3'd1;
        #1;
        chk("idx8_outA_phys9", 128'(bus.outA), 128'h0);

        // Simultaneous write and retreat at index 8
        bus.load_L = 1'b0; bus.selA = 3'd1; bus.in = 16'hA5A5; bus.winAddSub = 2'b01;
        tick();
        bus.load_L = 1'b1; bus.winAddSub = 2'b00; bus.selA = 3'd5; bus.selB = 3'd0;
        #1;
        chk("sim_outA_phys9", 128'(bus.outA), 128'hA5A5);
        chk("sim_outB_phys4", 128'(bus.outB), 128'h1234);

        // Reset overrides a concurrent write and advance
        reset = 1'b1; bus.load_L = 1'b0; bus.selA = 3'd0; bus.in = 16'h7777; bus.winAddSub = 2'b10;
        tick();
        reset = 1'b0; bus.load_L = 1'b1; bus.winAddSub = 2'b00; bus.selB = 3'd5;
        #1;
        chk("rst2_outA", 128'(bus.outA), 128'h0);
        chk("rst2_outB", 128'(bus.outB), 128'h0);
        chk("rst2_view", bus.outView, 128'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
